// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: parametrised UART transmitter with valid/ready input, run-time parity and
// stop-bit selection, per-frame done pulse and line-break generation.
//
// Parameters:
//   DATA_BITS   data bits per frame (5..9)
//   OVERSAMPLE  b_tick pulses per bit period (4..32)
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   b_tick       one-clk pulse at OVERSAMPLE x baud rate
//   tx_valid     frame offered on tx_data
//   tx_data      frame payload, sent LSB first
//   parity_mode  00 none, 01 even, 10 odd, 11 mark
//   stop2        0 = one stop bit, 1 = two stop bits
//   brk          line-break request, honoured only while idle
//   tx_ready     combinational: idle and no break requested
//   tx_busy      registered: high while a frame is in flight
//   tx_done      registered one-cycle pulse at end of frame
//   tx           registered serial line, idle high
module uart_tx_cfg #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 b_tick,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic [1:0]           parity_mode,
  input  logic                 stop2,
  input  logic                 brk,
  output logic                 tx_ready,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic                 tx
);

  localparam int unsigned TickW = $clog2(OVERSAMPLE);
  localparam int unsigned BitW  = $clog2(DATA_BITS + 1);

  localparam logic [TickW-1:0] TickLast = TickW'(OVERSAMPLE - 1);
  localparam logic [BitW-1:0]  BitLast  = BitW'(DATA_BITS - 1);

  localparam logic [1:0] ParNone = 2'b00;
  localparam logic [1:0] ParEven = 2'b01;
  localparam logic [1:0] ParOdd  = 2'b10;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e               state_q, state_d;
  logic [TickW-1:0]     tick_cnt_q, tick_cnt_d;
  logic [BitW-1:0]      bit_cnt_q, bit_cnt_d;

  // Frame registers, loaded on accept and held for the whole frame.
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [1:0]           par_mode_q, par_mode_d;
  logic                 par_bit_q, par_bit_d;
  logic                 stop2_q, stop2_d;

  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic                 accept;
  logic                 bit_end;
  logic                 par_new;

  assign tx_ready = (state_q == StIdle) && !brk;
  assign accept   = tx_valid && tx_ready;

  // Only ticks inside a bit period count; the accept-cycle tick is seen while still idle.
  assign bit_end  = b_tick && (state_q != StIdle) && (tick_cnt_q == TickLast);

  // Parity of the incoming payload, resolved once at accept time.
  always_comb begin
    par_new = 1'b0;
    unique case (parity_mode)
      ParNone: par_new = 1'b0;
      ParEven: par_new = ^tx_data;
      ParOdd:  par_new = ~(^tx_data);
      default: par_new = 1'b1;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_mode_d = par_mode_q;
    par_bit_d  = par_bit_q;
    stop2_d    = stop2_q;
    done_d     = 1'b0;

    if (state_q != StIdle && b_tick) begin
      tick_cnt_d = bit_end ? '0 : tick_cnt_q + 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        tick_cnt_d = '0;
        bit_cnt_d  = '0;
        if (accept) begin
          state_d    = StStart;
          shift_d    = tx_data;
          par_mode_d = parity_mode;
          par_bit_d  = par_new;
          stop2_d    = stop2;
        end
      end
      StStart: begin
        if (bit_end) begin
          state_d   = StData;
          bit_cnt_d = '0;
        end
      end
      StData: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == BitLast) begin
            bit_cnt_d = '0;
            state_d   = (par_mode_q != ParNone) ? StParity : StStop;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      StParity: begin
        if (bit_end) begin
          state_d   = StStop;
          bit_cnt_d = '0;
        end
      end
      StStop: begin
        if (bit_end) begin
          // bit_cnt distinguishes the first of two stop bits from the last.
          if (stop2_q && (bit_cnt_q == '0)) begin
            bit_cnt_d = BitW'(1);
          end else begin
            state_d   = StIdle;
            bit_cnt_d = '0;
            done_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Line level follows the current state, so tx trails each state change by one clk.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_q)
      StIdle:   tx_d = !brk;
      StStart:  tx_d = 1'b0;
      StData:   tx_d = shift_q[0];
      StParity: tx_d = par_bit_q;
      StStop:   tx_d = 1'b1;
      default:  tx_d = 1'b1;
    endcase
  end

  // Busy rises the cycle after accept and falls on the same edge as the return to idle.
  assign busy_d = (state_q != StIdle) && (state_d != StIdle);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_mode_q <= '0;
      par_bit_q  <= 1'b0;
      stop2_q    <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_mode_q <= par_mode_d;
      par_bit_q  <= par_bit_d;
      stop2_q    <= stop2_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign tx      = tx_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: an 8-bit/16x instance and a 7-bit/16x instance share
// clk, rst and a b_tick that pulses every 4 clk.
module tb_uart_tx_cfg;

  logic       clk;
  logic       rst;
  logic [1:0] div_q;
  logic       b_tick;

  logic       tx_valid8, tx_valid7;
  logic [7:0] tx_data8;
  logic [6:0] tx_data7;
  logic [1:0] parity_mode;
  logic       stop2;
  logic       brk;

  logic       rdy8, busy8, done8, tx8;
  logic       rdy7, busy7, done7, tx7;

  // Selects which instance the capture task observes.
  logic       sel;
  logic       c_tx, c_busy, c_done, c_ready;

  int n_checks;
  int n_fail;

  uart_tx_cfg #(.DATA_BITS(8), .OVERSAMPLE(16)) dut8 (
    .clk         (clk),
    .rst         (rst),
    .b_tick      (b_tick),
    .tx_valid    (tx_valid8),
    .tx_data     (tx_data8),
    .parity_mode (parity_mode),
    .stop2       (stop2),
    .brk         (brk),
    .tx_ready    (rdy8),
    .tx_busy     (busy8),
    .tx_done     (done8),
    .tx          (tx8)
  );

  uart_tx_cfg #(.DATA_BITS(7), .OVERSAMPLE(16)) dut7 (
    .clk         (clk),
    .rst         (rst),
    .b_tick      (b_tick),
    .tx_valid    (tx_valid7),
    .tx_data     (tx_data7),
    .parity_mode (parity_mode),
    .stop2       (stop2),
    .brk         (1'b0),
    .tx_ready    (rdy7),
    .tx_busy     (busy7),
    .tx_done     (done7),
    .tx          (tx7)
  );

  assign c_tx    = sel ? tx7   : tx8;
  assign c_busy  = sel ? busy7 : busy8;
  assign c_done  = sel ? done7 : done8;
  assign c_ready = sel ? rdy7  : rdy8;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial div_q = 2'd0;
  always @(posedge clk) div_q <= div_q + 2'd1;
  assign b_tick = (div_q == 2'd3);

  // Call just after the accept edge. Returns at the negedge where tx_done is first seen.
  // bits[i] is tx sampled mid-way through bit period i (0 = start bit).
  task automatic capture(input int os, output logic [15:0] bits, output int ticks,
                         output int seg, output logic tx_a, output logic busy_a,
                         output logic rdy_a, output logic tx_b, output logic busy_b,
                         output logic busy_end, output logic to);
    int   tr_n;
    int   tr_t [4];
    logic prev;
    bits = '0; ticks = 0; seg = 0; to = 1'b1; tr_n = 0; prev = 1'b1;
    tx_a = 1'bx; busy_a = 1'bx; rdy_a = 1'bx; tx_b = 1'bx; busy_b = 1'bx; busy_end = 1'bx;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (k == 0) begin tx_a = c_tx; busy_a = c_busy; rdy_a = c_ready; end
      if (k == 1) begin tx_b = c_tx; busy_b = c_busy; end
      if (c_done) begin
        busy_end = c_busy;
        to = 1'b0;
        break;
      end
      if (c_tx !== prev) begin
        if (tr_n < 4) tr_t[tr_n] = k;
        tr_n++;
      end
      prev = c_tx;
      if (b_tick) begin
        ticks++;
        if ((ticks % os) == (os / 2) && (ticks / os) < 16) bits[ticks / os] = c_tx;
      end
    end
    if (tr_n >= 3) seg = tr_t[2] - tr_t[1];
  endtask

  task automatic send8(input logic [7:0] d, input logic [1:0] pm, input logic s2);
    @(negedge clk);
    sel = 1'b0; tx_data8 = d; parity_mode = pm; stop2 = s2; tx_valid8 = 1'b1;
    @(posedge clk);
    #1 tx_valid8 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_checks++; if (tx8 !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b want 1", tx8); end
    n_checks++; if (busy8 !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy8); end
    n_checks++; if (done8 !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done8); end
    n_checks++; if (rdy8 !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", rdy8); end
    n_checks++; if (tx7 !== 1'b1) begin n_fail++; $display("FAIL reset_tx7: got %b want 1", tx7); end
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_8n1();
    logic [15:0] b; int t, s; logic ta, ba, ra, tb, bb, be, to;
    send8(8'h55, 2'b00, 1'b0);
    capture(16, b, t, s, ta, ba, ra, tb, bb, be, to);
    n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL 8n1_timeout: got %b want 0", to); end
    n_checks++; if (ra !== 1'b0) begin n_fail++; $display("FAIL 8n1_ready_drop: got %b want 0", ra); end
    n_checks++; if ({ta, ba} !== 2'b10) begin n_fail++; $display("FAIL 8n1_edge_n: got tx/busy %b%b want 10", ta, ba); end
    n_checks++; if ({tb, bb} !== 2'b01) begin n_fail++; $display("FAIL 8n1_edge_n1: got tx/busy %b%b want 01", tb, bb); end
    n_checks++; if (b[9:0] !== 10'h2AA) begin n_fail++; $display("FAIL 8n1_bits: got %h want 2aa", b[9:0]); end
    n_checks++; if (t !== 160) begin n_fail++; $display("FAIL 8n1_ticks: got %0d want 160", t); end
    n_checks++; if (s !== 64) begin n_fail++; $display("FAIL 8n1_bit_clks: got %0d want 64", s); end
    n_checks++; if (be !== 1'b0) begin n_fail++; $display("FAIL 8n1_busy_at_done: got %b want 0", be); end
    n_checks++; if (c_ready !== 1'b1) begin n_fail++; $display("FAIL 8n1_ready_at_done: got %b want 1", c_ready); end
    @(negedge clk);
    n_checks++; if (c_done !== 1'b0) begin n_fail++; $display("FAIL 8n1_done_pulse: got %b want 0", c_done); end
  endtask

  task automatic test_parity();
    logic [7:0] pd [4] = '{8'h55, 8'h55, 8'h55, 8'h07};
    logic [1:0] pm [4] = '{2'b01, 2'b10, 2'b11, 2'b01};
    logic       pe [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic [15:0] b; int t, s; logic ta, ba, ra, tb, bb, be, to;
    for (int i = 0; i < 4; i++) begin
      send8(pd[i], pm[i], 1'b0);
      capture(16, b, t, s, ta, ba, ra, tb, bb, be, to);
      n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL par%0d_timeout: got %b want 0", i, to); end
      n_checks++; if (t !== 176) begin n_fail++; $display("FAIL par%0d_ticks: got %0d want 176", i, t); end
      n_checks++; if (b[8:1] !== pd[i]) begin n_fail++; $display("FAIL par%0d_data: got %h want %h", i, b[8:1], pd[i]); end
      n_checks++; if (b[9] !== pe[i]) begin n_fail++; $display("FAIL par%0d_bit: got %b want %b", i, b[9], pe[i]); end
      n_checks++; if ({b[10], b[0]} !== 2'b10) begin n_fail++; $display("FAIL par%0d_framing: got %b%b want 10", i, b[10], b[0]); end
      @(negedge clk);
    end
  endtask

  task automatic test_stop2_7bit();
    logic [15:0] b; int t, s; logic ta, ba, ra, tb, bb, be, to;
    @(negedge clk);
    sel = 1'b1; tx_data7 = 7'h41; parity_mode = 2'b00; stop2 = 1'b1; tx_valid7 = 1'b1;
    @(posedge clk);
    #1 tx_valid7 = 1'b0;
    capture(16, b, t, s, ta, ba, ra, tb, bb, be, to);
    n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL s2_timeout: got %b want 0", to); end
    n_checks++; if (t !== 160) begin n_fail++; $display("FAIL s2_ticks: got %0d want 160", t); end
    n_checks++; if (b[9:0] !== 10'h382) begin n_fail++; $display("FAIL s2_bits: got %h want 382", b[9:0]); end
    @(negedge clk);
    sel = 1'b0; stop2 = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [15:0] b; int t, s; logic ta, ba, ra, tb, bb, be, to;
    @(negedge clk);
    sel = 1'b0; tx_data8 = 8'hA5; parity_mode = 2'b01; stop2 = 1'b0; tx_valid8 = 1'b1;
    @(posedge clk);
    // Inputs change right after accept; valid stays high for the second frame.
    #1 tx_data8 = 8'h3C; parity_mode = 2'b10;
    capture(16, b, t, s, ta, ba, ra, tb, bb, be, to);
    n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL b2b1_timeout: got %b want 0", to); end
    n_checks++; if (b[10:0] !== 11'h54A) begin n_fail++; $display("FAIL b2b1_bits: got %h want 54a", b[10:0]); end
    n_checks++; if (t !== 176) begin n_fail++; $display("FAIL b2b1_ticks: got %0d want 176", t); end
    n_checks++; if (c_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready: got %b want 1", c_ready); end
    @(posedge clk);
    #1 tx_valid8 = 1'b0;
    capture(16, b, t, s, ta, ba, ra, tb, bb, be, to);
    n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL b2b2_timeout: got %b want 0", to); end
    n_checks++; if ({tb, bb} !== 2'b01) begin n_fail++; $display("FAIL b2b2_start: got tx/busy %b%b want 01", tb, bb); end
    n_checks++; if (b[10:0] !== 11'h678) begin n_fail++; $display("FAIL b2b2_bits: got %h want 678", b[10:0]); end
    n_checks++; if (t !== 176) begin n_fail++; $display("FAIL b2b2_ticks: got %0d want 176", t); end
    @(negedge clk);
    parity_mode = 2'b00;
  endtask

  task automatic test_break();
    logic [15:0] b; int t, s; logic ta, ba, ra, tb, bb, be, to;
    send8(8'h55, 2'b00, 1'b0);
    fork
      capture(16, b, t, s, ta, ba, ra, tb, bb, be, to);
      begin
        repeat (200) @(negedge clk);
        brk = 1'b1; tx_data8 = 8'hF0; tx_valid8 = 1'b1;
      end
    join
    n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL brk_timeout: got %b want 0", to); end
    n_checks++; if (b[9:0] !== 10'h2AA) begin n_fail++; $display("FAIL brk_frame_bits: got %h want 2aa", b[9:0]); end
    n_checks++; if (c_ready !== 1'b0) begin n_fail++; $display("FAIL brk_ready: got %b want 0", c_ready); end
    repeat (10) @(negedge clk);
    n_checks++; if (tx8 !== 1'b0) begin n_fail++; $display("FAIL brk_line: got %b want 0", tx8); end
    n_checks++; if ({busy8, rdy8} !== 2'b00) begin n_fail++; $display("FAIL brk_hold: got busy/ready %b%b want 00", busy8, rdy8); end
    brk = 1'b0;
    @(posedge clk);
    #1 tx_valid8 = 1'b0;
    capture(16, b, t, s, ta, ba, ra, tb, bb, be, to);
    n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL brk_post_timeout: got %b want 0", to); end
    n_checks++; if ({ta, tb} !== 2'b10) begin n_fail++; $display("FAIL brk_release: got tx %b%b want 10", ta, tb); end
    n_checks++; if (b[9:0] !== 10'h3E0) begin n_fail++; $display("FAIL brk_post_bits: got %h want 3e0", b[9:0]); end
    n_checks++; if (t !== 160) begin n_fail++; $display("FAIL brk_post_ticks: got %0d want 160", t); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [15:0] b; int t, s; logic ta, ba, ra, tb, bb, be, to;
    int dones;
    send8(8'hC3, 2'b00, 1'b0);
    repeat (200) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_checks++; if (tx8 !== 1'b1) begin n_fail++; $display("FAIL rstmid_tx: got %b want 1", tx8); end
    n_checks++; if (busy8 !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", busy8); end
    n_checks++; if (rdy8 !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready: got %b want 1", rdy8); end
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    for (int k = 0; k < 700; k++) begin
      @(negedge clk);
      if (done8 === 1'b1) dones++;
    end
    n_checks++; if (dones !== 0) begin n_fail++; $display("FAIL rstmid_no_done: got %0d want 0", dones); end
    send8(8'hFF, 2'b00, 1'b0);
    capture(16, b, t, s, ta, ba, ra, tb, bb, be, to);
    n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL rstmid_ff_timeout: got %b want 0", to); end
    n_checks++; if (b[9:0] !== 10'h3FE) begin n_fail++; $display("FAIL rstmid_ff_bits: got %h want 3fe", b[9:0]); end
    n_checks++; if (t !== 160) begin n_fail++; $display("FAIL rstmid_ff_ticks: got %0d want 160", t); end
    @(negedge clk);
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    sel = 1'b0; rst = 1'b1; brk = 1'b0; stop2 = 1'b0; parity_mode = 2'b00;
    tx_valid8 = 1'b0; tx_valid7 = 1'b0; tx_data8 = '0; tx_data7 = '0;
    test_reset();
    test_8n1();
    test_parity();
    test_stop2_7bit();
    test_back_to_back();
    test_break();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_cfg.md
# uart_tx_cfg

Parametrised UART transmitter, the successor to the fixed 8N1 transmitter in the UART loopback path. It supports a configurable data width and oversampling ratio, run-time parity and stop-bit selection, a valid/ready input handshake, a per-frame done pulse, and line-break generation. It sits between the TX FIFO read port and the `tx` pin and is driven by the shared oversampled baud tick.

## Interface
- `DATA_BITS`, default 8: data bits per frame, legal range 5..9.
- `OVERSAMPLE`, default 16: `b_tick` pulses per bit period, legal range 4..32.
- `clk`  in  1  system clock; all logic is on its rising edge.
- `rst`  in  1  reset; one clock, synchronous, active-high.
- `b_tick`  in  1  one-`clk` pulse at OVERSAMPLE × baud rate.
- `tx_valid`  in  1  a frame is offered on `tx_data`.
- `tx_data`  in  DATA_BITS  frame payload; sent LSB first.
- `parity_mode`  in  2  00 none, 01 even, 10 odd, 11 mark (always 1).
- `stop2`  in  1  0 = one stop bit, 1 = two stop bits.
- `brk`  in  1  line-break request; honoured only while idle.
- `tx_ready`  out  1  combinational: `state==IDLE && !brk`.
- `tx_busy`  out  1  registered; high from the cycle after accept until the frame ends.
- `tx_done`  out  1  registered one-cycle pulse at end of frame.
- `tx`  out  1  registered serial line output; idle level is 1.

## Operation
- **States:** IDLE, START, DATA, PARITY, STOP.
- **Accept:** a frame is accepted on a `clk` edge where `tx_valid && tx_ready`.
  - `tx_data`, `parity_mode` and `stop2` are latched into frame registers.
  - Input changes after accept do not affect the frame in flight.
- **Tick counter:** `tick_cnt` is $clog2(OVERSAMPLE) bits wide and cleared on every state or bit change.
  - A bit period ends on the `b_tick` where `tick_cnt==OVERSAMPLE-1`.
  - `b_tick` pulses outside the current bit period are ignored.
- **IDLE:** `tx`=1, or `tx`=0 while `brk`=1. `tx_busy`=0.
- **START:** `tx`=0 for one bit period, then go to DATA with `bit_cnt`=0.
- **DATA:** `tx`=`shift[0]`.
  - At each bit-period end: shift right and increment `bit_cnt` (width $clog2(DATA_BITS+1)).
  - After bit DATA_BITS-1: go to PARITY if the latched mode ≠ 00, otherwise go to STOP.
- **PARITY:** `tx` = parity bit for one bit period, then go to STOP.
  - Even: XOR-reduction of the latched data.
  - Odd: the inverse of the even bit.
  - Mark: 1.
- **STOP:** `tx`=1 for one bit period, or two if the latched `stop2`=1 (counted with `bit_cnt`). Then go to IDLE and pulse `tx_done`.
- **Frame length:** OVERSAMPLE × (1 + DATA_BITS + P + S) `b_tick`s, where P ∈ {0,1} and S ∈ {1,2}.
- **Break:**
  - `brk` asserted mid-frame has no effect until the frame completes.
  - `brk` asserted in IDLE drives `tx` low from the next edge and holds `tx_ready` low.
  - Deasserting `brk` restores `tx`=1 on the next edge.

## Timing
- **Reset values** (after the first edge with `rst`=1, regardless of the current state): `tx`=1, `tx_busy`=0, `tx_done`=0, state IDLE, `tick_cnt`=0, `bit_cnt`=0, and all frame registers 0. `tx_ready`=1 if `brk`=0.
- **Reset mid-frame:** the frame is aborted and `tx` returns to 1 on that edge. No `tx_done` is produced.
- **Accept to start bit:**
  - Accept at edge N: `tx` falls to 0 and `tx_busy` rises at edge N+1.
  - `tx_ready` drops combinationally once the state leaves IDLE, i.e. after edge N.
- **Bit changes:** `tx` changes one `clk` after the `b_tick` that ends the bit period.
- **End of frame:** `tx_done`=1, `tx_busy`=0 and state IDLE all appear on the same edge. `tx_ready` is high in that cycle, so back-to-back frames have zero `b_tick` gap.
- **Accept with `b_tick` on the same cycle:** that `b_tick` does not count toward the start bit.
- **`tx_valid` held high in IDLE with `brk`=1:** no accept occurs. The frame is accepted on the first edge after `brk` falls.

## Test plan
- **8N1 basic:** `DATA_BITS`=8, `OVERSAMPLE`=16, `b_tick` every 4 clk. Send 0x55 with `parity_mode`=00, `stop2`=0 → `tx` shows 0,1,0,1,0,1,0,1,0,1 at 64 clk per bit, frame is 160 b_ticks, `tx_done` pulses once, `tx_busy` falls on the same edge.
- **Parity:** send 0x55 with even parity → parity bit 0. Odd → 1. Mark → 1. Send 0x07 with even parity → 1. Frame is 176 b_ticks.
- **Two stop bits with a 7-bit instance:** `DATA_BITS`=7, send 0x41 with `stop2`=1 → `tx` high for 32 b_ticks after bit 6, total 160 b_ticks.
- **Back-to-back and latching:** hold `tx_valid`=1 and send 0xA5 then 0x3C; change `tx_data` and `parity_mode` mid-frame → the first frame is unaffected, the second start bit begins 1 clk after `tx_done`, no idle tick.
- **Break:** assert `brk` mid-frame → the frame completes normally, then `tx`=0 and `tx_ready`=0 while `brk`=1. Deassert → `tx`=1 on the next edge, then a pending `tx_valid` is accepted.
- **Reset mid-frame:** pulse `rst` during DATA → `tx`=1, `tx_busy`=0, no `tx_done`. A new 0xFF frame then transmits correctly.
